mips_mc_ctrl: RTL and testbench

Multi-cycle MIPS control unit: the initiator side that sequences the datapath (ALU, register file, shift/sign-extend units, state registers).
- Moore FSM plus a combinational ALU decoder.
- Decodes the latched instruction's op/funct fields and drives every datapath select and write strobe, one micro-step per clock.
- Supports lw, sw, R-type (add/sub/and/or/slt), beq, addi, j.

---
 rtl/mips_ctrl_pkg.sv | 53 +++++
 rtl/mips_mc_ctrl_if.sv | 33 +++
 rtl/mips_alu_decoder.sv | 35 +++
 rtl/mips_mc_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_mips_mc_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: shared types and constants for the multi-cycle MIPS control unit.
//   - state_t   : controller FSM states (4-bit)
//   - OP_*/FN_* : opcode and R-type funct encodings
//   - ALU_*     : ALU F codes driven on alucontrol
//   - aluop_t   : request from the FSM to the ALU decoder
//   - SRCB_*/PCSRC_* : datapath mux select encodings
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
      S_ALUWB, S_BEQEX, S_ADDIEX, S_ADDIWB, S_JEX, S_BNEEX
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // ALUOP_NONE parks alucontrol at 000 in states that do not use the ALU.
   typedef enum logic [1:0] {
      ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT, ALUOP_NONE
   } aluop_t;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // States that stall on the memory wait counter.
   function automatic logic is_wait_state(state_t s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// mips_mc_ctrl_if: control bus between the MIPS controller and its datapath.
//   master (controller): reads op/funct/zero, drives all selects and strobes.
//   slave  (datapath)  : drives op/funct/zero, reads selects and strobes.
interface mips_mc_ctrl_if;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       pcen;
   logic       memwrite;
   logic       irwrite;
   logic       regwrite;
   logic       iord;
   logic       memtoreg;
   logic       regdst;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] pcsrc;
   logic [2:0] alucontrol;
   logic       illegal_op;
   logic       busy_wait;

   modport master (
      input  op, funct, zero,
      output pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
             alusrca, alusrcb, pcsrc, alucontrol, illegal_op, busy_wait
   );

   modport slave (
      output op, funct, zero,
      input  pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
             alusrca, alusrcb, pcsrc, alucontrol, illegal_op, busy_wait
   );
endinterface

// File: rtl/mips_alu_decoder.sv
// mips_alu_decoder: combinational ALU control decode.
//   aluop         in  : add / sub / decode-from-funct / none
//   funct         in  : instruction[5:0]
//   alucontrol    out : ALU F code (000 when idle or funct undecodable)
//   funct_illegal out : funct not a supported R-type op (only with ALUOP_FUNCT)
module mips_alu_decoder
   import mips_ctrl_pkg::*;
(
   input  aluop_t     aluop,
   input  logic [5:0] funct,
   output logic [2:0] alucontrol,
   output logic       funct_illegal
);

   always_comb begin
      alucontrol    = ALU_AND;
      funct_illegal = 1'b0;
      case (aluop)
         ALUOP_ADD: alucontrol = ALU_ADD;
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               FN_ADD:  alucontrol = ALU_ADD;
               FN_SUB:  alucontrol = ALU_SUB;
               FN_AND:  alucontrol = ALU_AND;
               FN_OR:   alucontrol = ALU_OR;
               FN_SLT:  alucontrol = ALU_SLT;
               default: funct_illegal = 1'b1;
            endcase
         end
         default: alucontrol = ALU_AND;
      endcase
   end

endmodule

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle MIPS control unit (Moore FSM + ALU decoder).
//   clk   in : rising-edge clock
//   reset in : asynchronous, active-high reset
//   bus      : mips_mc_ctrl_if.master (op/funct/zero in, selects/strobes out)
// Parameter MEM_WAIT (0..15): extra wait cycles in FETCH, MEMRD and MEMWR.
// Optional feature macro MIPS_CTRL_BNE_EN: when defined, op 000101 (bne)
// executes through BNEEX; otherwise it is decoded as illegal.
module mips_mc_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT = 0
) (
   input  logic           clk,
   input  logic           reset,
   mips_mc_ctrl_if.master bus
);

   localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

   state_t     state, state_n;
   logic [3:0] cnt;
   logic       cnt_zero;

   logic       pcwrite, branch, branch_ne;
   logic       memwrite, irwrite, regwrite, illegal;
   logic       iord, memtoreg, regdst, alusrca;
   logic [1:0] alusrcb, pcsrc;
   aluop_t     aluop;
   logic [2:0] alucontrol;
   logic       funct_illegal;

   assign cnt_zero = (cnt == 4'd0);

   mips_alu_decoder u_alu_dec (
      .aluop         (aluop),
      .funct         (bus.funct),
      .alucontrol    (alucontrol),
      .funct_illegal (funct_illegal)
   );

   // The counter reloads on every entry into a wait state; while a wait state
   // holds (counter nonzero) it simply counts down.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_FETCH;
         cnt   <= WAIT_INIT;
      end else begin
         state <= state_n;
         if ((state_n != state) && is_wait_state(state_n))
            cnt <= WAIT_INIT;
         else if (!cnt_zero)
            cnt <= cnt - 4'd1;
      end
   end

   always_comb begin
      state_n   = state;
      pcwrite   = 1'b0;
      branch    = 1'b0;
      branch_ne = 1'b0;
      memwrite  = 1'b0;
      irwrite   = 1'b0;
      regwrite  = 1'b0;
      illegal   = 1'b0;
      iord      = 1'b0;
      memtoreg  = 1'b0;
      regdst    = 1'b0;
      alusrca   = 1'b0;
      alusrcb   = SRCB_B;
      pcsrc     = PCSRC_ALU;
      aluop     = ALUOP_NONE;
      case (state)
         S_FETCH: begin
            alusrcb = SRCB_FOUR;
            aluop   = ALUOP_ADD;
            if (cnt_zero) begin
               irwrite = 1'b1;
               pcwrite = 1'b1;
               state_n = S_DECODE;
            end
         end
         S_DECODE: begin
            // Branch target computed speculatively into ALUOut.
            alusrcb = SRCB_IMM_SH;
            aluop   = ALUOP_ADD;
            case (bus.op)
               OP_LW, OP_SW: state_n = S_MEMADR;
               OP_RTYPE:     state_n = S_EXEC;
               OP_BEQ:       state_n = S_BEQEX;
               OP_ADDI:      state_n = S_ADDIEX;
               OP_J:         state_n = S_JEX;
`ifdef MIPS_CTRL_BNE_EN
               OP_BNE:       state_n = S_BNEEX;
`else
               OP_BNE: begin
                  illegal = 1'b1;
                  state_n = S_FETCH;
               end
`endif
               default: begin
                  illegal = 1'b1;
                  state_n = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
            aluop   = ALUOP_ADD;
            state_n = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            iord = 1'b1;
            if (cnt_zero) state_n = S_MEMWB;
         end
         S_MEMWB: begin
            memtoreg = 1'b1;
            regwrite = 1'b1;
            state_n  = S_FETCH;
         end
         S_MEMWR: begin
            iord = 1'b1;
            if (cnt_zero) begin
               memwrite = 1'b1;
               state_n  = S_FETCH;
            end
         end
         S_EXEC: begin
            alusrca = 1'b1;
            aluop   = ALUOP_FUNCT;
            // Undecodable funct aborts before write-back.
            if (funct_illegal) begin
               illegal = 1'b1;
               state_n = S_FETCH;
            end else begin
               state_n = S_ALUWB;
            end
         end
         S_ALUWB: begin
            regdst   = 1'b1;
            regwrite = 1'b1;
            state_n  = S_FETCH;
         end
         S_BEQEX: begin
            alusrca = 1'b1;
            aluop   = ALUOP_SUB;
            pcsrc   = PCSRC_ALUOUT;
            branch  = 1'b1;
            state_n = S_FETCH;
         end
         S_BNEEX: begin
            alusrca   = 1'b1;
            aluop     = ALUOP_SUB;
            pcsrc     = PCSRC_ALUOUT;
            branch_ne = 1'b1;
            state_n   = S_FETCH;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = SRCB_IMM;
            aluop   = ALUOP_ADD;
            state_n = S_ADDIWB;
         end
         S_ADDIWB: begin
            regwrite = 1'b1;
            state_n  = S_FETCH;
         end
         S_JEX: begin
            pcsrc   = PCSRC_JUMP;
            pcwrite = 1'b1;
            state_n = S_FETCH;
         end
         default: state_n = S_FETCH;
      endcase
   end

   // Strobes are masked by reset itself so nothing fires while reset is held,
   // even though FETCH with a zero counter would otherwise assert irwrite/pcen.
   assign bus.pcen       = ~reset & (pcwrite | (branch & bus.zero)
                                             | (branch_ne & ~bus.zero));
   assign bus.memwrite   = ~reset & memwrite;
   assign bus.irwrite    = ~reset & irwrite;
   assign bus.regwrite   = ~reset & regwrite;
   assign bus.illegal_op = ~reset & illegal;
   assign bus.iord       = iord;
   assign bus.memtoreg   = memtoreg;
   assign bus.regdst     = regdst;
   assign bus.alusrca    = alusrca;
   assign bus.alusrcb    = alusrcb;
   assign bus.pcsrc      = pcsrc;
   assign bus.alucontrol = alucontrol;
   assign bus.busy_wait  = ~cnt_zero & is_wait_state(state);

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: directed checks of mips_mc_ctrl with MEM_WAIT=0 (dut0)
// and MEM_WAIT=2 (dut1).
module tb_mips_mc_ctrl;
   import mips_ctrl_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mips_mc_ctrl_if b0 ();
   mips_mc_ctrl_if b1 ();

   mips_mc_ctrl #(.MEM_WAIT(0)) dut0 (.clk(clk), .reset(reset), .bus(b0.master));
   mips_mc_ctrl #(.MEM_WAIT(2)) dut1 (.clk(clk), .reset(reset), .bus(b1.master));

   typedef struct packed {
      logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
      logic [1:0] alusrcb, pcsrc;
      logic [2:0] alucontrol;
      logic       illegal_op;
   } snap_t;

   snap_t      cur0;
   logic [4:0] strb0, vec1;
   assign cur0  = {b0.pcen, b0.memwrite, b0.irwrite, b0.regwrite, b0.iord, b0.memtoreg,
                   b0.regdst, b0.alusrca, b0.alusrcb, b0.pcsrc, b0.alucontrol, b0.illegal_op};
   assign strb0 = {b0.pcen, b0.memwrite, b0.irwrite, b0.regwrite, b0.illegal_op};
   assign vec1  = {b1.irwrite, b1.iord, b1.busy_wait, b1.regwrite, b1.memtoreg};

   int    n_chk = 0, n_pass = 0;
   snap_t tr [0:19];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Record one instruction on dut0, from its FETCH cycle until the next FETCH.
   task automatic run0(output int cyc);
      cyc = 0;
      do begin
         tr[cyc] = cur0;
         cyc++;
         tick();
      end while (!b0.irwrite && cyc < 20);
   endtask

   task automatic sync0();
      for (int i = 0; i < 20 && !b0.irwrite; i++) tick();
   endtask

   task automatic tally(input int n, output int rw, output int mw, output int ill);
      rw = 0; mw = 0; ill = 0;
      for (int i = 0; i < n; i++) begin
         rw  += int'(tr[i].regwrite);
         mw  += int'(tr[i].memwrite);
         ill += int'(tr[i].illegal_op);
      end
   endtask

   task automatic set0(input logic [5:0] op, input logic [5:0] funct, input logic zero);
      b0.op = op; b0.funct = funct; b0.zero = zero;
   endtask

   // dut1 lw trace, MEM_WAIT=2: {irwrite, iord, busy_wait, regwrite, memtoreg}
   logic [4:0] lw2 [0:9];

   initial begin
      int cyc, rw, mw, ill;
      lw2 = '{5'b00100, 5'b00100, 5'b10000, 5'b00000, 5'b00000,
              5'b01100, 5'b01100, 5'b01000, 5'b00011, 5'b00100};
      reset = 1'b1;
      set0(OP_LW, 6'd0, 1'b0);
      b1.op = OP_LW; b1.funct = 6'd0; b1.zero = 1'b0;

      // Reset state
      repeat (2) tick();
      chk("rst_strobes", strb0, 5'b0);
      chk("rst_sel", {b0.iord, b0.alusrca, b0.alusrcb, b0.alucontrol}, {1'b0, 1'b0, SRCB_FOUR, ALU_ADD});
      chk("rst_busy1", b1.busy_wait, 1'b1);
      @(negedge clk); reset = 1'b0; #1;
      chk("rel_irwrite", b0.irwrite, 1'b1);

      // Reset in the middle of MEMRD
      tick(); tick(); tick();
      chk("memrd_iord", {b0.iord, b0.regwrite}, 2'b10);
      #2 reset = 1'b1; #1;
      chk("midrst_strobes", strb0, 5'b0);
      chk("midrst_iord", b0.iord, 1'b0);
      @(negedge clk); reset = 1'b0; #1;
      chk("rel2_irwrite", b0.irwrite, 1'b1);

      // MEM_WAIT=2 lw on dut1: 3 FETCH, DECODE, MEMADR, 3 MEMRD, MEMWB, back to FETCH
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("lw_w2_c%0d", i + 1), vec1, lw2[i]);
         if (i < 9) tick();
      end
      b1.op = OP_J;

      sync0();

      // R-type sub
      set0(OP_RTYPE, FN_SUB, 1'b0);
      run0(cyc);
      chk("sub_cycles", cyc, 4);
      chk("sub_decode_srcb", tr[1].alusrcb, SRCB_IMM_SH);
      chk("sub_exec", {tr[2].alusrca, tr[2].alusrcb, tr[2].alucontrol}, {1'b1, SRCB_B, ALU_SUB});
      chk("sub_aluwb", {tr[3].regwrite, tr[3].regdst, tr[3].memtoreg}, 3'b110);

      // lw, no wait
      set0(OP_LW, 6'd0, 1'b0);
      run0(cyc);
      chk("lw_cycles", cyc, 5);
      chk("lw_memadr", {tr[2].alusrca, tr[2].alusrcb}, {1'b1, SRCB_IMM});
      chk("lw_memrd_iord", tr[3].iord, 1'b1);
      chk("lw_memwb", {tr[4].regwrite, tr[4].memtoreg, tr[4].regdst}, 3'b110);

      // sw
      set0(OP_SW, 6'd0, 1'b0);
      run0(cyc);
      tally(cyc, rw, mw, ill);
      chk("sw_cycles", cyc, 4);
      chk("sw_memwr", {tr[3].memwrite, tr[3].iord}, 2'b11);
      chk("sw_mw_count", mw, 1);
      chk("sw_rw_count", rw, 0);

      // beq taken / not taken
      set0(OP_BEQ, 6'd0, 1'b1);
      run0(cyc);
      chk("beq_t_cycles", cyc, 3);
      chk("beq_t_ex", {tr[2].pcen, tr[2].pcsrc, tr[2].alucontrol}, {1'b1, PCSRC_ALUOUT, ALU_SUB});
      set0(OP_BEQ, 6'd0, 1'b0);
      run0(cyc);
      chk("beq_nt_cycles", cyc, 3);
      chk("beq_nt_pcen", tr[2].pcen, 1'b0);

      // addi
      set0(OP_ADDI, 6'd0, 1'b0);
      run0(cyc);
      chk("addi_cycles", cyc, 4);
      chk("addi_ex", {tr[2].alusrca, tr[2].alusrcb, tr[2].alucontrol}, {1'b1, SRCB_IMM, ALU_ADD});
      chk("addi_wb", {tr[3].regwrite, tr[3].regdst, tr[3].memtoreg}, 3'b100);

      // j
      set0(OP_J, 6'd0, 1'b0);
      run0(cyc);
      chk("j_cycles", cyc, 3);
      chk("j_ex", {tr[2].pcen, tr[2].pcsrc}, {1'b1, PCSRC_JUMP});

      // illegal opcode
      set0(6'b111111, 6'd0, 1'b0);
      run0(cyc);
      tally(cyc, rw, mw, ill);
      chk("illop_cycles", cyc, 2);
      chk("illop_pulse", tr[1].illegal_op, 1'b1);
      chk("illop_counts", {ill[3:0], rw[3:0], mw[3:0]}, 12'h100);

      // illegal funct
      set0(OP_RTYPE, 6'b000111, 1'b0);
      run0(cyc);
      tally(cyc, rw, mw, ill);
      chk("illfn_cycles", cyc, 3);
      chk("illfn_exec", {tr[2].illegal_op, tr[2].alucontrol}, {1'b1, 3'b000});
      chk("illfn_counts", {ill[3:0], rw[3:0], mw[3:0]}, 12'h100);

      // bne
      set0(OP_BNE, 6'd0, 1'b0);
      run0(cyc);
`ifdef MIPS_CTRL_BNE_EN
      chk("bne_cycles", cyc, 3);
      chk("bne_ex", {tr[2].pcen, tr[2].pcsrc}, {1'b1, PCSRC_ALUOUT});
`else
      chk("bne_ill_cycles", cyc, 2);
      chk("bne_ill_pulse", tr[1].illegal_op, 1'b1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
